// File: rtl/mem_io_arbiter.sv
// Two-requester sequencer for the shared data-memory / IO port.
// CPU and loader take turns through a req/ack handshake.
module mem_io_arbiter #(
    parameter int          MEM_LAT  = 1,
    parameter int          MEM_AW   = 14,
    parameter logic [21:0] IO_BASE  = 22'h3FFFFF,
    parameter bit          LDR_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_ack,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              io_rd,
    output logic              io_wr,
    output logic              led_cs,
    output logic              sw_cs,
    output logic              seg_cs,
    output logic [31:0]       io_wdata,
    input  logic [15:0]       io_rdata
);

    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cpu_ackd;
    logic          ldr_ackd;
    logic          last_ldr;
    logic          sel_ldr;
    logic          we_q;
    logic          io_q;
    logic          sw_rd_q;
    logic [31:0]   wdata_q;

    logic          cpu_elig;
    logic          ldr_elig;
    logic          pick_ldr;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic          w_io;
    logic [3:0]    w_nib;
    logic          led_hit;
    logic          sw_hit;
    logic          seg_hit;

    logic          unused_addr;
    assign unused_addr = ^{cpu_addr[1:0], ldr_addr[1:0]};

    // A requester acked last cycle sits out one IDLE cycle.
    assign cpu_elig = cpu_req & ~cpu_ackd;
    assign ldr_elig = ldr_req & ~ldr_ackd;
    assign pick_ldr = ldr_elig &
                      (~cpu_elig | LDR_PRIO | ~last_ldr);

    assign w_we    = pick_ldr ? ldr_we    : cpu_we;
    assign w_addr  = pick_ldr ? ldr_addr  : cpu_addr;
    assign w_wdata = pick_ldr ? ldr_wdata : cpu_wdata;

    assign w_io    = (w_addr[31:10] == IO_BASE);
    assign w_nib   = w_addr[7:4];
    assign led_hit = w_io & (w_nib == 4'd6) & w_we;
    assign sw_hit  = w_io & (w_nib == 4'd7) & ~w_we;
    assign seg_hit = w_io & (w_nib == 4'd8) & w_we;

    assign mem_wdata = wdata_q;
    assign io_wdata  = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cpu_ackd <= 1'b0;
            ldr_ackd <= 1'b0;
            last_ldr <= 1'b1;
            sel_ldr  <= 1'b0;
            we_q     <= 1'b0;
            io_q     <= 1'b0;
            sw_rd_q  <= 1'b0;
            wdata_q  <= '0;
            cpu_ack  <= 1'b0;
            ldr_ack  <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            io_rd    <= 1'b0;
            io_wr    <= 1'b0;
            led_cs   <= 1'b0;
            sw_cs    <= 1'b0;
            seg_cs   <= 1'b0;
        end else begin
            cpu_ackd <= cpu_ack;
            ldr_ackd <= ldr_ack;
            case (state)
                IDLE: begin
                    if (cpu_elig || ldr_elig) begin
                        sel_ldr  <= pick_ldr;
                        last_ldr <= pick_ldr;
                        we_q     <= w_we;
                        io_q     <= w_io;
                        sw_rd_q  <= sw_hit;
                        wdata_q  <= w_wdata;
                        mem_addr <= w_addr[MEM_AW+1:2];
                        mem_en   <= ~w_io;
                        mem_we   <= ~w_io & w_we;
                        io_rd    <= sw_hit;
                        io_wr    <= led_hit | seg_hit;
                        led_cs   <= led_hit;
                        sw_cs    <= sw_hit;
                        seg_cs   <= seg_hit;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    io_rd  <= 1'b0;
                    io_wr  <= 1'b0;
                    led_cs <= 1'b0;
                    sw_cs  <= 1'b0;
                    seg_cs <= 1'b0;
                    if (!io_q && !we_q) begin
                        cnt   <= CW'(MEM_LAT);
                        state <= WAIT;
                    end else begin
                        cpu_ack <= ~sel_ldr;
                        ldr_ack <= sel_ldr;
                        state   <= RESP;
                    end
                    // Unmapped and wrong-direction IO reads return zero.
                    if (io_q && !we_q) begin
                        rdata <= sw_rd_q ? {16'h0, io_rdata} : '0;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        rdata   <= mem_rdata;
                        cpu_ack <= ~sel_ldr;
                        ldr_ack <= sel_ldr;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Directed bench for mem_io_arbiter: vector table plus
// contention, double-issue and mid-transaction reset sequences.
module tb_mem_io_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ack;
    logic        ldr_req, ldr_we;
    logic [31:0] ldr_addr, ldr_wdata;
    logic        ldr_ack;
    logic [31:0] rdata;
    logic        busy;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        io_rd, io_wr;
    logic        led_cs, sw_cs, seg_cs;
    logic [31:0] io_wdata;
    logic [15:0] io_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_io_arbiter #(
        .MEM_LAT (1),
        .MEM_AW  (14),
        .IO_BASE (22'h3FFFFF),
        .LDR_PRIO(1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .ldr_req  (ldr_req),
        .ldr_we   (ldr_we),
        .ldr_addr (ldr_addr),
        .ldr_wdata(ldr_wdata),
        .ldr_ack  (ldr_ack),
        .rdata    (rdata),
        .busy     (busy),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .led_cs   (led_cs),
        .sw_cs    (sw_cs),
        .seg_cs   (seg_cs),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata)
    );

    typedef struct {
        logic        ldr;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic [15:0] iord;
        logic [6:0]  strb;
        logic [13:0] maddr;
        int          lat;
        logic [31:0] rdat;
    } vec_t;

    vec_t v[12];

    function automatic logic [6:0] strobes();
        return {mem_en, mem_we, io_rd, io_wr,
                led_cs, sw_cs, seg_cs};
    endfunction

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string nm);
        check({nm, "_outs"},
              {22'h0, cpu_ack, ldr_ack, busy, strobes()},
              32'h0);
        check({nm, "_rdata"}, rdata, 32'h0);
    endtask

    task automatic wait_ack(output int t);
        t = 1;
        while (!(cpu_ack | ldr_ack) && t < 12) begin
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        if (!(cpu_ack | ldr_ack)) t = 0;
    endtask

    task automatic run_vec(input vec_t x, input int idx);
        int t;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(posedge clk);
        #1;
        cpu_we    = x.we;
        cpu_addr  = x.addr;
        cpu_wdata = x.wdata;
        ldr_we    = x.we;
        ldr_addr  = x.addr;
        ldr_wdata = x.wdata;
        mem_rdata = x.mrd;
        io_rdata  = x.iord;
        cpu_req   = ~x.ldr;
        ldr_req   = x.ldr;
        @(posedge clk);
        @(negedge clk);
        check({nm, "_strobes"}, {25'h0, strobes()},
              {25'h0, x.strb});
        check({nm, "_busy"}, {31'h0, busy}, 32'h1);
        check({nm, "_mem_wdata"}, mem_wdata, x.wdata);
        check({nm, "_io_wdata"}, io_wdata, x.wdata);
        if (x.strb[6])
            check({nm, "_mem_addr"}, {18'h0, mem_addr},
                  {18'h0, x.maddr});
        wait_ack(t);
        check({nm, "_latency"}, t, x.lat);
        check({nm, "_acks"}, {30'h0, cpu_ack, ldr_ack},
              x.ldr ? 32'h1 : 32'h2);
        check({nm, "_rdata"}, rdata, x.rdat);
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        @(negedge clk);
        check({nm, "_ack_pulse"},
              {30'h0, cpu_ack, ldr_ack}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t;
        int n;
        int ovl;
        int nack;
        int at[4];
        logic aw[4];

        v[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF,
                  32'h0, 16'h0, 7'b1100000, 14'd4, 2,
                  32'h0};
        v[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,
                  32'hDEAD_BEEF, 16'h0, 7'b1000000, 14'd4, 3,
                  32'hDEAD_BEEF};
        v[2]  = '{1'b1, 1'b0, 32'hFFFF_FC70, 32'h0,
                  32'h0, 16'hA5F0, 7'b0010010, 14'd0, 2,
                  32'h0000_A5F0};
        v[3]  = '{1'b1, 1'b1, 32'hFFFF_FC60, 32'h55,
                  32'h0, 16'h0, 7'b0001100, 14'd0, 2,
                  32'h0000_A5F0};
        v[4]  = '{1'b1, 1'b0, 32'hFFFF_FC90, 32'h0,
                  32'h0, 16'hA5F0, 7'b0000000, 14'd0, 2,
                  32'h0};
        v[5]  = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,
                  32'h1234_5678, 16'h0, 7'b1000000, 14'd9, 3,
                  32'h1234_5678};
        v[6]  = '{1'b0, 1'b1, 32'hFFFF_FC70, 32'h1,
                  32'h0, 16'h0, 7'b0000000, 14'd0, 2,
                  32'h1234_5678};
        v[7]  = '{1'b1, 1'b1, 32'hFFFF_FC80, 32'h3F,
                  32'h0, 16'h0, 7'b0001001, 14'd0, 2,
                  32'h1234_5678};
        v[8]  = '{1'b0, 1'b0, 32'hFFFF_FC60, 32'h0,
                  32'h0, 16'hBEEF, 7'b0000000, 14'd0, 2,
                  32'h0};
        v[9]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,
                  32'h0BAD_F00D, 16'h0, 7'b1000000, 14'd4, 3,
                  32'h0BAD_F00D};
        v[10] = '{1'b0, 1'b1, 32'h8000_0040, 32'hCAFE_F00D,
                  32'h0, 16'h0, 7'b1100000, 14'h10, 2,
                  32'h0BAD_F00D};
        v[11] = '{1'b1, 1'b0, 32'hFFFF_FC80, 32'h0,
                  32'h0, 16'h1234, 7'b0000000, 14'd0, 2,
                  32'h0};

        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ldr_req   = 1'b0;
        ldr_we    = 1'b0;
        ldr_addr  = '0;
        ldr_wdata = '0;
        mem_rdata = '0;
        io_rdata  = '0;
        #2;
        check_reset_outs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(v[i], i);

        // Contention from reset: CPU, loader, CPU, loader.
        do_reset();
        @(posedge clk);
        #1;
        cpu_we   = 1'b1;
        cpu_addr = 32'h20;
        ldr_we   = 1'b1;
        ldr_addr = 32'h30;
        cpu_req  = 1'b1;
        ldr_req  = 1'b1;
        @(posedge clk);
        n   = 0;
        ovl = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (cpu_ack && ldr_ack) ovl++;
            if ((cpu_ack || ldr_ack) && n < 4) begin
                at[n] = k;
                aw[n] = ldr_ack;
                n++;
            end
            @(posedge clk);
            if (k == 9) begin
                #1;
                cpu_req = 1'b0;
                ldr_req = 1'b0;
            end
        end
        check("rr_ack_count", n, 4);
        check("rr_overlap", ovl, 0);
        check("rr_t0", at[0], 2);
        check("rr_w0", {31'h0, aw[0]}, 32'h0);
        check("rr_t1", at[1], 5);
        check("rr_w1", {31'h0, aw[1]}, 32'h1);
        check("rr_t2", at[2], 8);
        check("rr_w2", {31'h0, aw[2]}, 32'h0);
        check("rr_t3", at[3], 11);
        check("rr_w3", {31'h0, aw[3]}, 32'h1);

        // Loader holds req through the mask cycle.
        @(posedge clk);
        #1;
        ldr_we   = 1'b1;
        ldr_addr = 32'h40;
        ldr_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_ack(t);
        check("hold_latency", t, 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        ldr_req = 1'b0;
        @(negedge clk);
        check("hold_no_reissue", {31'h0, busy}, 32'h0);
        nack = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ack || ldr_ack) nack++;
        end
        check("hold_no_ack", nack, 0);

        // Reset during WAIT abandons the read.
        run_vec('{1'b0, 1'b0, 32'h50, 32'h0, 32'h77,
                  16'h0, 7'b1000000, 14'd20, 3, 32'h77}, 12);
        @(posedge clk);
        #1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h60;
        mem_rdata = 32'h99;
        cpu_req   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("wait_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid_reset");
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nack = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ack || ldr_ack) nack++;
        end
        check("mid_reset_no_ack", nack, 0);
        check("mid_reset_idle", {31'h0, busy}, 32'h0);
        run_vec(v[1], 13);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule
